// File: rtl/mem_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_bridge_if
// Bundles the controller-side and memory-side signals of mem_bridge.
//
// Controller side : cpu_req, cpu_we, cpu_adr, cpu_wdata -> bridge
//                   cpu_rdata, stall, err               <- bridge
// Memory side     : mem_req, mem_we, mem_adr, mem_wdata <- bridge
//                   mem_ack, mem_rdata                  -> bridge
//
// Handshake: the bridge raises mem_req with mem_we/mem_adr/mem_wdata and
// holds all four stable until the memory returns a one-cycle mem_ack
// strobe; mem_rdata is only looked at in the mem_ack cycle of a read.
// The controller holds cpu_req while it needs the access and advances
// only in a cycle where stall is low.
//
// modport slave  : the bridge itself
// modport master : the environment (controller + memory) driving the bridge
// ---------------------------------------------------------------------------
interface mem_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_adr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              stall;
   logic              err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wdata, mem_ack, mem_rdata,
      output cpu_rdata, stall, err, mem_req, mem_we, mem_adr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wdata, mem_ack, mem_rdata,
      input  cpu_rdata, stall, err, mem_req, mem_we, mem_adr, mem_wdata
   );
endinterface

// File: rtl/mem_bridge.sv
// ---------------------------------------------------------------------------
// mem_bridge
// Connects the multicycle MIPS controller/datapath to one shared
// instruction/data memory with a variable-latency req/ack handshake.
// Each access is captured at issue and held until mem_ack; read data is
// returned through a holding register; stall freezes the controller until
// the access completes. Misaligned addresses and memory timeouts raise a
// sticky err and park the bridge in ERR until reset.
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : mem_bridge_if.slave (controller + memory signals)
//   state_o : current FSM state (IDLE=0, ACCESS=1, DONE=2, ERR=3), debug
// ---------------------------------------------------------------------------
module mem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15   // legal 1..255
) (
   input  logic          clk,
   input  logic          reset,
   mem_bridge_if.slave   bus,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Last count value before the timeout fires; the counter therefore
   // never reaches TIMEOUT itself and cannot wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_adr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic              err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_adr_q   <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cpu_req) begin
                  if (bus.cpu_adr[1:0] != 2'b00) begin
                     // Misaligned: never touch memory.
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end else begin
                     mem_adr_q   <= bus.cpu_adr;
                     mem_we_q    <= bus.cpu_we;
                     mem_wdata_q <= bus.cpu_wdata;
                     mem_req_q   <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               // mem_ack is tested first so it wins over a same-cycle timeout.
               if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!mem_we_q) begin
                     cpu_rdata_q <= bus.mem_rdata;
                  end
                  state_q <= S_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= S_ERR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               // One-cycle release; a still-high cpu_req is re-evaluated in IDLE.
               state_q <= S_IDLE;
            end
            S_ERR: begin
               mem_req_q <= 1'b0;
               state_q   <= S_ERR;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.stall     = ((state_q == S_IDLE) && bus.cpu_req) ||
                          (state_q == S_ACCESS) || (state_q == S_ERR);
   assign bus.err       = err_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_adr   = mem_adr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_ERR    = 2'd3;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state;

   always #5 clk = ~clk;

   mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (state)
   );

   // ---------------- scoreboard counters ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   // Advance one rising edge and settle 2 time units past it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic cpu_drive(input logic req, input logic we,
                            input logic [31:0] adr, input logic [31:0] wd);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_adr   = adr;
      bus.cpu_wdata = wd;
   endtask

   task automatic mem_drive(input logic ack, input logic [31:0] rd);
      bus.mem_ack   = ack;
      bus.mem_rdata = rd;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b0;
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      mem_drive(1'b0, 32'h0);
      tick();
      tick();

      // Reset state
      chk("rst_state",   32'(state),         32'(ST_IDLE));
      chk("rst_mem_req", 32'(bus.mem_req),   32'd0);
      chk("rst_mem_we",  32'(bus.mem_we),    32'd0);
      chk("rst_mem_adr", bus.mem_adr,        32'h0);
      chk("rst_wdata",   bus.mem_wdata,      32'h0);
      chk("rst_rdata",   bus.cpu_rdata,      32'h0);
      chk("rst_err",     32'(bus.err),       32'd0);
      chk("rst_stall",   32'(bus.stall),     32'd0);
      reset = 1'b1;
      tick();

      // ---- Fetch, zero wait ----
      cpu_drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
      #1;
      chk("f_stall_idle", 32'(bus.stall),   32'd1);
      chk("f_req_idle",   32'(bus.mem_req), 32'd0);
      tick();                                   // ACCESS
      chk("f_req_acc",    32'(bus.mem_req), 32'd1);
      chk("f_adr_acc",    bus.mem_adr,      32'h0000_0004);
      chk("f_we_acc",     32'(bus.mem_we),  32'd0);
      chk("f_stall_acc",  32'(bus.stall),   32'd1);
      mem_drive(1'b1, 32'h2008_0005);
      tick();                                   // DONE
      mem_drive(1'b0, 32'h0);
      chk("f_state_done", 32'(state),       32'(ST_DONE));
      chk("f_stall_done", 32'(bus.stall),   32'd0);
      chk("f_req_done",   32'(bus.mem_req), 32'd0);
      chk("f_rdata",      bus.cpu_rdata,    32'h2008_0005);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();                                   // IDLE
      chk("f_state_idle", 32'(state),       32'(ST_IDLE));

      // ---- sw with 3 wait states ----
      cpu_drive(1'b1, 1'b1, 32'h0000_0050, 32'hDEAD_BEEF);
      #1;
      chk("sw_stall_idle", 32'(bus.stall), 32'd1);
      tick();                                   // ACCESS cycle 1
      // Controller-side changes during ACCESS must not leak to memory.
      cpu_drive(1'b1, 1'b0, 32'h0000_0099, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("sw_req_c%0d", i),   32'(bus.mem_req), 32'd1);
         chk($sformatf("sw_we_c%0d", i),    32'(bus.mem_we),  32'd1);
         chk($sformatf("sw_adr_c%0d", i),   bus.mem_adr,      32'h0000_0050);
         chk($sformatf("sw_wd_c%0d", i),    bus.mem_wdata,    32'hDEAD_BEEF);
         chk($sformatf("sw_stall_c%0d", i), 32'(bus.stall),   32'd1);
         if (i == 4) mem_drive(1'b1, 32'h1111_1111);
         tick();
      end
      mem_drive(1'b0, 32'h0);
      chk("sw_state_done", 32'(state),       32'(ST_DONE));
      chk("sw_stall_done", 32'(bus.stall),   32'd0);
      chk("sw_we_done",    32'(bus.mem_we),  32'd0);
      chk("sw_req_done",   32'(bus.mem_req), 32'd0);
      chk("sw_rdata_keep", bus.cpu_rdata,    32'h2008_0005);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // ---- lw then fetch back-to-back, cpu_req held across DONE ----
      cpu_drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
      tick();                                   // ACCESS
      chk("lw_adr", bus.mem_adr, 32'h0000_0100);
      mem_drive(1'b1, 32'hCAFE_0001);
      tick();                                   // DONE
      mem_drive(1'b0, 32'h0);
      cpu_drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
      #1;
      chk("lw_stall_done", 32'(bus.stall),   32'd0);
      chk("lw_rdata",      bus.cpu_rdata,    32'hCAFE_0001);
      chk("lw_req_done",   32'(bus.mem_req), 32'd0);
      tick();                                   // IDLE, no access yet
      chk("b2b_state_idle", 32'(state),       32'(ST_IDLE));
      chk("b2b_req_idle",   32'(bus.mem_req), 32'd0);
      chk("b2b_stall_idle", 32'(bus.stall),   32'd1);
      tick();                                   // ACCESS for fetch
      chk("b2b_req_acc",    32'(bus.mem_req), 32'd1);
      chk("b2b_adr_acc",    bus.mem_adr,      32'h0000_0008);
      mem_drive(1'b1, 32'h8C82_0000);
      tick();                                   // DONE
      mem_drive(1'b0, 32'h0);
      chk("b2b_rdata",      bus.cpu_rdata,    32'h8C82_0000);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // ---- mem_ack in IDLE ignored ----
      mem_drive(1'b1, 32'h0000_0BAD);
      tick();
      mem_drive(1'b0, 32'h0);
      chk("idle_ack_rdata", bus.cpu_rdata,    32'h8C82_0000);
      chk("idle_ack_state", 32'(state),       32'(ST_IDLE));
      chk("idle_ack_req",   32'(bus.mem_req), 32'd0);

      // ---- Timeout: 15 ACCESS cycles without mem_ack ----
      cpu_drive(1'b1, 1'b0, 32'h0000_0200, 32'h0);
      tick();                                   // ACCESS cycle 1
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 1; i <= 15; i++) begin
         chk($sformatf("to_req_c%0d", i), 32'(bus.mem_req), 32'd1);
         chk($sformatf("to_err_c%0d", i), 32'(bus.err),     32'd0);
         tick();
      end
      chk("to_state", 32'(state),       32'(ST_ERR));
      chk("to_req",   32'(bus.mem_req), 32'd0);
      chk("to_err",   32'(bus.err),     32'd1);
      chk("to_stall", 32'(bus.stall),   32'd1);
      mem_drive(1'b1, 32'hFFFF_FFFF);           // late ack
      tick();
      mem_drive(1'b0, 32'h0);
      chk("to_late_rdata", bus.cpu_rdata, 32'h8C82_0000);
      chk("to_late_err",   32'(bus.err),  32'd1);
      chk("to_late_state", 32'(state),    32'(ST_ERR));
      reset = 1'b0;
      #1;
      chk("to_rst_err",   32'(bus.err),   32'd0);
      chk("to_rst_stall", 32'(bus.stall), 32'd0);
      chk("to_rst_state", 32'(state),     32'(ST_IDLE));
      tick();
      reset = 1'b1;
      tick();

      // ---- Misaligned address ----
      cpu_drive(1'b1, 1'b0, 32'h0000_0006, 32'h0);
      #1;
      chk("mis_stall_idle", 32'(bus.stall), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("mis_req_%0d", i),   32'(bus.mem_req), 32'd0);
         chk($sformatf("mis_err_%0d", i),   32'(bus.err),     32'd1);
         chk($sformatf("mis_stall_%0d", i), 32'(bus.stall),   32'd1);
      end
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      #1;
      chk("mis_rst_err",   32'(bus.err),   32'd0);
      chk("mis_rst_stall", 32'(bus.stall), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // ---- Reset mid-access ----
      cpu_drive(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
      tick();                                   // ACCESS cycle 1
      tick();                                   // ACCESS cycle 2
      chk("mid_req_before", 32'(bus.mem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_req",   32'(bus.mem_req),   32'd0);
      chk("mid_we",    32'(bus.mem_we),    32'd0);
      chk("mid_adr",   bus.mem_adr,        32'h0);
      chk("mid_wd",    bus.mem_wdata,      32'h0);
      chk("mid_rdata", bus.cpu_rdata,      32'h0);
      chk("mid_err",   32'(bus.err),       32'd0);
      chk("mid_state", 32'(state),         32'(ST_IDLE));
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      cpu_drive(1'b1, 1'b0, 32'h0000_000C, 32'h0);
      tick();                                   // ACCESS
      chk("post_req", 32'(bus.mem_req), 32'd1);
      chk("post_adr", bus.mem_adr,      32'h0000_000C);
      mem_drive(1'b1, 32'h0000_ABCD);
      tick();                                   // DONE
      mem_drive(1'b0, 32'h0);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      chk("post_rdata", bus.cpu_rdata,  32'h0000_ABCD);
      chk("post_stall", 32'(bus.stall), 32'd0);
      chk("post_err",   32'(bus.err),   32'd0);
      tick();

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
